// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared constants, FSM state type and cycle-count helper for the GF(2^m) multiplier.
package gf2m_pkg;

    localparam int GF_M = 163;
    localparam logic [162:0] GF_POLY_163 = 163'hC9;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/gf2m_mulx_d.sv
// gf2m_mulx_d: combinational x^j multiples of an element of GF(2^M), j = 0..D.
//   x     in   M    field element
//   terms out  D*M  slice j holds x*x^j mod f, j = 0..D-1
//   x_d   out  M    x*x^D mod f
module gf2m_mulx_d
    import gf2m_pkg::*;
#(
    parameter int M = GF_M,
    parameter int D = 4,
    parameter logic [M-1:0] POLY = M'(GF_POLY_163)
) (
    input  logic [M-1:0]   x,
    output logic [D*M-1:0] terms,
    output logic [M-1:0]   x_d
);

    logic [M-1:0] t;

    // One shift per step; a bit leaving x^(M-1) folds back in as POLY.
    always_comb begin
        t = x;
        terms = '0;
        for (int j = 0; j < D; j++) begin
            terms[j*M +: M] = t;
            t = (t << 1) ^ (t[M-1] ? POLY : '0);
        end
        x_d = t;
    end

endmodule

// File: rtl/gf2m_digit_mult.sv
// gf2m_digit_mult: digit-serial LSB-first GF(2^M) multiplier, z = a*b mod f, D bits of b per cycle.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b)
//   out_valid / out_ready result handshake (z)
//   busy                  high while the digit loop runs
//   GF2M_MULT_SQR_EN      adds input sqr: load B from a, giving z = a^2 mod f
module gf2m_digit_mult
    import gf2m_pkg::*;
#(
    parameter int M = GF_M,
    parameter int D = 4,
    parameter logic [M-1:0] POLY = M'(GF_POLY_163)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
`ifdef GF2M_MULT_SQR_EN
    input  logic         sqr,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] z,
    output logic         busy
);

    localparam int NDIG = ceil_div(M, D);
    localparam int CW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t         state;
    logic [M-1:0]   a_r, b_r, c_r, c_next, a_next, b_load;
    logic [D*M-1:0] terms;
    logic [CW-1:0]  cnt;
    logic           take;

    gf2m_mulx_d #(.M(M), .D(D), .POLY(POLY)) u_mulx (
        .x    (a_r),
        .terms(terms),
        .x_d  (a_next)
    );

    // b_r shifts in zeros, so a short final digit contributes nothing above bit M-1.
    always_comb begin
        c_next = c_r;
        for (int j = 0; j < D; j++)
            c_next = c_next ^ (b_r[j] ? terms[j*M +: M] : '0);
    end

`ifdef GF2M_MULT_SQR_EN
    assign b_load = sqr ? a : b;
`else
    assign b_load = b;
`endif

    // A finished result may hand over to the next operation in the same cycle.
    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign take = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            c_r       <= '0;
            cnt       <= '0;
            z         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (take) begin
            a_r       <= a;
            b_r       <= b_load;
            c_r       <= '0;
            cnt       <= '0;
            state     <= RUN;
            busy      <= 1'b1;
            out_valid <= 1'b0;
        end else if (state == RUN) begin
            a_r <= a_next;
            b_r <= b_r >> D;
            c_r <= c_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                z         <= c_next;
                state     <= DONE;
                busy      <= 1'b0;
                out_valid <= 1'b1;
            end
        end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gf2m_digit_mult.sv
// tb_gf2m_digit_mult: testbench for gf2m_digit_mult over several digit sizes.
module tb_gf2m_digit_mult;

    localparam int NI = 5;
    localparam logic [162:0] F_LOW = 163'hC9;

    function automatic int dig(input int i);
        return i == 0 ? 1 : i == 1 ? 3 : i == 2 ? 4 : i == 3 ? 8 : 163;
    endfunction

    function automatic int lat(input int i);
        return (163 + dig(i) - 1) / dig(i) + 1;
    endfunction

    logic clk, rst_n, in_valid, out_ready;
    logic [162:0] a, b;
`ifdef GF2M_MULT_SQR_EN
    logic sqr;
`endif
    logic [NI-1:0] ir, ov, bz, ov_d;
    logic [162:0] zv [NI];
    logic [162:0] exp_q [NI][$];
    int start [NI];
    int cyc, checks, errors;

    genvar i;
    for (i = 0; i < NI; i++) begin : g_dut
        gf2m_digit_mult #(.D(dig(i))) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (ir[i]),
            .a        (a),
            .b        (b),
`ifdef GF2M_MULT_SQR_EN
            .sqr      (sqr),
`endif
            .out_valid(ov[i]),
            .out_ready(out_ready),
            .z        (zv[i]),
            .busy     (bz[i])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [162:0] got, input logic [162:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [162:0] gf_mul(input logic [162:0] x, input logic [162:0] y);
        logic [162:0] r = '0;
        for (int k = 162; k >= 0; k--) begin
            r = {r[161:0], 1'b0} ^ (r[162] ? F_LOW : '0);
            if (y[k]) r ^= x;
        end
        return r;
    endfunction

    function automatic logic [162:0] rnd163();
        logic [191:0] t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[162:0];
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            ov_d <= '0;
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (in_valid && ir[k]) start[k] <= cyc;
                if (ov[k] && !ov_d[k])
                    check($sformatf("latency D=%0d", dig(k)), 163'(cyc - start[k]), 163'(lat(k)));
                if (ov[k] && out_ready) begin
                    if (exp_q[k].size() == 0) check($sformatf("unexpected D=%0d", dig(k)), 163'(ov[k]), '0);
                    else check($sformatf("z D=%0d", dig(k)), zv[k], exp_q[k].pop_front());
                end
            end
            ov_d <= ov;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!(&ir) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) check("ready timeout", 163'(ir), 163'({NI{1'b1}}));
    endtask

    task automatic wait_idle();
        int n = 0;
        int pend = 1;
        while (n < 1000) begin
            pend = 0;
            for (int k = 0; k < NI; k++) pend += exp_q[k].size();
            if ((&ir) && pend == 0) break;
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) check("idle timeout", 163'(pend), '0);
    endtask

    task automatic issue(input logic [162:0] x, input logic [162:0] y, input logic s,
                         input logic [162:0] e, input logic hold);
        wait_ready();
        a = x;
        b = y;
`ifdef GF2M_MULT_SQR_EN
        sqr = s;
`endif
        in_valid = 1'b1;
        for (int k = 0; k < NI; k++) exp_q[k].push_back(e);
        @(posedge clk); #1;
        if (hold) begin
            b = ~y;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic mul(input logic [162:0] x, input logic [162:0] y, input logic hold);
        issue(x, y, 1'b0, gf_mul(x, y), hold);
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s z D=%0d", tag, dig(k)), zv[k], '0);
            check($sformatf("%s out_valid D=%0d", tag, dig(k)), 163'(ov[k]), '0);
            check($sformatf("%s busy D=%0d", tag, dig(k)), 163'(bz[k]), '0);
            check($sformatf("%s in_ready D=%0d", tag, dig(k)), 163'(ir[k]), 163'(1));
        end
    endtask

    initial begin
        logic [162:0] x, y, e;
        clk = 0; rst_n = 0; in_valid = 0; out_ready = 1; a = '0; b = '0; cyc = 0;
        checks = 0; errors = 0;
`ifdef GF2M_MULT_SQR_EN
        sqr = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1;
        @(posedge clk); #1;

        issue(163'd1, 163'd2, 1'b0, 163'd2, 1'b0);
        issue(163'd1 << 162, 163'd2, 1'b0, 163'hC9, 1'b1);
        mul('1, '1, 1'b0);
        for (int n = 0; n < 200; n++) mul(rnd163(), rnd163(), n[0]);
        wait_idle();

        // result held under back-pressure, then handed straight to the next operation
        out_ready = 1'b0;
        x = rnd163(); y = rnd163(); e = gf_mul(x, y);
        mul(x, y, 1'b0);
        begin
            int n = 0;
            while (!(&ov) && n < 400) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 400) check("out_valid timeout", 163'(ov), 163'({NI{1'b1}}));
        end
        repeat (10) begin
            @(posedge clk); #1;
            for (int k = 0; k < NI; k++) begin
                check($sformatf("hold out_valid D=%0d", dig(k)), 163'(ov[k]), 163'(1));
                check($sformatf("hold z D=%0d", dig(k)), zv[k], e);
                check($sformatf("hold in_ready D=%0d", dig(k)), 163'(ir[k]), '0);
            end
        end
        out_ready = 1'b1;
        mul(rnd163(), rnd163(), 1'b0);
        wait_idle();

        // reset in the middle of a run
        mul(rnd163(), rnd163(), 1'b0);
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrun");
        for (int k = 0; k < NI; k++) exp_q[k].delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        mul(rnd163(), rnd163(), 1'b0);
        wait_idle();

`ifdef GF2M_MULT_SQR_EN
        issue(163'd1 << 100, rnd163(), 1'b1,
              (163'd1 << 44) | (163'd1 << 43) | (163'd1 << 40) | (163'd1 << 37), 1'b0);
        x = rnd163();
        issue(x, rnd163(), 1'b1, gf_mul(x, x), 1'b0);
        wait_idle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
